ret_stack: RTL and testbench

Parametrised return-address stack for the calculator CPU's call/return path, replacing the single-entry enabled return-address register so that nested `jal` calls up to DEPTH levels return correctly. The fetch stage pushes the link address on a call and pops on a return; the top entry feeds the PC mux directly. The block also reports occupancy and sticky overflow/underflow errors, and has a selectable full-stack policy: drop the new entry, or overwrite the oldest one.

---
 rtl/ret_stack_pkg.sv | 21 ++
 rtl/ret_stack_mem.sv | 27 ++
 rtl/ret_stack.sv | 131 +++++++++++++
 tb/tb_ret_stack.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ret_stack_pkg.sv
// Shared constants and helpers for the return-address stack.
// Policy encodings for the WRAP parameter and a ceiling-log2 used for port/pointer widths.
package ret_stack_pkg;

   localparam int RS_WRAP_DROP      = 0;
   localparam int RS_WRAP_OVERWRITE = 1;

   function automatic int rs_clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/ret_stack_mem.sv
// DEPTH x WIDTH storage for the return stack.
// Has one synchronous write port and one asynchronous read port.
module ret_stack_mem #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Write port: array contents carry no reset, validity comes from the owner's count.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/ret_stack.sv
// Return-address stack: circular storage, pointer/count bookkeeping and sticky error flags.
// The top entry is read combinationally from the registered pointer, so q follows each edge at once.
module ret_stack
   import ret_stack_pkg::*;
#(
   parameter  int WIDTH = 10,
   parameter  int DEPTH = 8,
   parameter  int WRAP  = 0,
   localparam int CW    = rs_clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] d,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   localparam int PW = rs_clog2(DEPTH);

   logic [PW-1:0]    wp_r;
   logic [CW-1:0]    count_r;
   logic             ovf_r;
   logic             unf_r;

   logic [PW-1:0]    wp_inc_s;
   logic [PW-1:0]    top_idx_s;
   logic [PW-1:0]    wp_nxt_s;
   logic [CW-1:0]    count_nxt_s;
   logic             we_s;
   logic [PW-1:0]    waddr_s;
   logic             ovf_set_s;
   logic             unf_set_s;
   logic             empty_s;
   logic             full_s;
   logic [WIDTH-1:0] rdata_s;

   assign empty_s   = (count_r == {CW{1'b0}});
   assign full_s    = (count_r == CW'(DEPTH));
   // Explicit wrap keeps modulo-DEPTH correct for non-power-of-two depths.
   assign wp_inc_s  = (wp_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : (wp_r + PW'(1));
   assign top_idx_s = (wp_r == {PW{1'b0}}) ? PW'(DEPTH - 1) : (wp_r - PW'(1));

   // Command decode: next pointer/count, write strobe and error events.
   always_comb begin
      wp_nxt_s    = wp_r;
      count_nxt_s = count_r;
      we_s        = 1'b0;
      waddr_s     = wp_r;
      ovf_set_s   = 1'b0;
      unf_set_s   = 1'b0;
      case ({push, pop})
         2'b10: begin
            if (!full_s) begin
               we_s        = 1'b1;
               wp_nxt_s    = wp_inc_s;
               count_nxt_s = count_r + CW'(1);
            end else if (WRAP == RS_WRAP_OVERWRITE) begin
               we_s      = 1'b1;
               wp_nxt_s  = wp_inc_s;
               ovf_set_s = 1'b1;
            end else begin
               ovf_set_s = 1'b1;
            end
         end
         2'b01: begin
            if (!empty_s) begin
               wp_nxt_s    = top_idx_s;
               count_nxt_s = count_r - CW'(1);
            end else begin
               unf_set_s = 1'b1;
            end
         end
         2'b11: begin
            if (!empty_s) begin
               we_s    = 1'b1;
               waddr_s = top_idx_s;
            end else begin
               we_s        = 1'b1;
               wp_nxt_s    = wp_inc_s;
               count_nxt_s = count_r + CW'(1);
            end
         end
         default: begin
            wp_nxt_s = wp_r;
         end
      endcase
   end

   // State registers; a new error on the same edge as clr_err leaves the flag set.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wp_r    <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else begin
         wp_r    <= wp_nxt_s;
         count_r <= count_nxt_s;
         ovf_r   <= ovf_set_s | (ovf_r & ~clr_err);
         unf_r   <= unf_set_s | (unf_r & ~clr_err);
      end
   end

   ret_stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (we_s & reset),
      .waddr (waddr_s),
      .wdata (d),
      .raddr (top_idx_s),
      .rdata (rdata_s)
   );

   assign q     = empty_s ? {WIDTH{1'b0}} : rdata_s;
   assign count = count_r;
   assign empty = empty_s;
   assign full  = full_s;
   assign ovf   = ovf_r;
   assign unf   = unf_r;

endmodule

// File: tb/tb_ret_stack.sv
// Directed plus random bench for ret_stack: a drop-policy and an overwrite-policy instance share stimulus,
// expectations come from a shifting-array stack model and are queued, then compared after each edge.
module tb_ret_stack;
   import ret_stack_pkg::*;

   localparam int WIDTH = 10;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   typedef struct packed {
      logic [WIDTH-1:0] q;
      logic [CW-1:0]    count;
      logic             empty;
      logic             full;
      logic             ovf;
      logic             unf;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset, push, pop, clr_err;
   logic [WIDTH-1:0] d;

   logic [WIDTH-1:0] q_dr, q_wr;
   logic [CW-1:0]    count_dr, count_wr;
   logic             empty_dr, empty_wr, full_dr, full_wr;
   logic             ovf_dr, ovf_wr, unf_dr, unf_wr;

   int tests = 0;
   int fails = 0;

   exp_t             sb[$];
   logic [WIDTH-1:0] mst [2][DEPTH];
   int               msz [2];
   logic             movf [2];
   logic             munf [2];

   always #5 clk = ~clk;

   ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(RS_WRAP_DROP)) u_drop (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .d(d), .clr_err(clr_err),
      .q(q_dr), .count(count_dr), .empty(empty_dr), .full(full_dr), .ovf(ovf_dr), .unf(unf_dr)
   );

   ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(RS_WRAP_OVERWRITE)) u_wrap (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .d(d), .clr_err(clr_err),
      .q(q_wr), .count(count_wr), .empty(empty_wr), .full(full_wr), .ovf(ovf_wr), .unf(unf_wr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: index 0 is the oldest entry; a full overwrite push shifts everything down by one.
   task automatic model(input int w);
      exp_t e;
      logic ovs, uns;
      ovs = 1'b0;
      uns = 1'b0;
      if (!reset) begin
         msz[w]  = 0;
         movf[w] = 1'b0;
         munf[w] = 1'b0;
      end else begin
         if (push && pop) begin
            if (msz[w] > 0) mst[w][msz[w]-1] = d;
            else begin mst[w][0] = d; msz[w] = 1; end
         end else if (push) begin
            if (msz[w] < DEPTH) begin
               mst[w][msz[w]] = d;
               msz[w]++;
            end else begin
               ovs = 1'b1;
               if (w == 1) begin
                  for (int i = 0; i < DEPTH - 1; i++) mst[w][i] = mst[w][i+1];
                  mst[w][DEPTH-1] = d;
               end
            end
         end else if (pop) begin
            if (msz[w] > 0) msz[w]--;
            else uns = 1'b1;
         end
         movf[w] = ovs | (movf[w] & ~clr_err);
         munf[w] = uns | (munf[w] & ~clr_err);
      end
      e.q     = (msz[w] > 0) ? mst[w][msz[w]-1] : '0;
      e.count = CW'(msz[w]);
      e.empty = (msz[w] == 0);
      e.full  = (msz[w] == DEPTH);
      e.ovf   = movf[w];
      e.unf   = munf[w];
      sb.push_back(e);
   endtask

   task automatic step(input logic p, input logic o, input logic [WIDTH-1:0] dv,
                       input logic c, input logic r);
      exp_t e;
      push = p; pop = o; d = dv; clr_err = c; reset = r;
      model(0);
      model(1);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("drop.q", 32'(q_dr), 32'(e.q));
      chk("drop.count", 32'(count_dr), 32'(e.count));
      chk("drop.empty", 32'(empty_dr), 32'(e.empty));
      chk("drop.full", 32'(full_dr), 32'(e.full));
      chk("drop.ovf", 32'(ovf_dr), 32'(e.ovf));
      chk("drop.unf", 32'(unf_dr), 32'(e.unf));
      e = sb.pop_front();
      chk("wrap.q", 32'(q_wr), 32'(e.q));
      chk("wrap.count", 32'(count_wr), 32'(e.count));
      chk("wrap.empty", 32'(empty_wr), 32'(e.empty));
      chk("wrap.full", 32'(full_wr), 32'(e.full));
      chk("wrap.ovf", 32'(ovf_wr), 32'(e.ovf));
      chk("wrap.unf", 32'(unf_wr), 32'(e.unf));
      @(negedge clk);
   endtask

   initial begin
      push = 1'b0; pop = 1'b0; d = '0; clr_err = 1'b0; reset = 1'b0;
      @(negedge clk);
      step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
      chk("reset_q", 32'(q_dr), 32'h0);
      chk("reset_empty", 32'(empty_wr), 32'h1);

      // Basic LIFO
      step(1'b1, 1'b0, 10'h010, 1'b0, 1'b1);
      step(1'b1, 1'b0, 10'h020, 1'b0, 1'b1);
      step(1'b1, 1'b0, 10'h030, 1'b0, 1'b1);
      chk("lifo_top", 32'(q_dr), 32'h030);
      chk("lifo_count", 32'(count_dr), 32'h3);
      step(1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
      chk("lifo_pop1", 32'(q_dr), 32'h020);
      step(1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
      step(1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
      chk("lifo_empty", 32'(empty_dr), 32'h1);

      // Overflow: drop keeps 1..4, overwrite keeps 3..6
      for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 10'(i), 1'b0, 1'b1);
      chk("drop_top", 32'(q_dr), 32'h004);
      chk("drop_ovf", 32'(ovf_dr), 32'h1);
      chk("wrap_top", 32'(q_wr), 32'h006);
      chk("wrap_full", 32'(full_wr), 32'h1);
      step(1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
      chk("drop_pop1", 32'(q_dr), 32'h003);
      chk("wrap_pop1", 32'(q_wr), 32'h005);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
      step(1'b0, 1'b0, 10'h000, 1'b1, 1'b1);

      // Underflow and clear priority
      step(1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
      chk("unf_set", 32'(unf_dr), 32'h1);
      step(1'b0, 1'b1, 10'h000, 1'b1, 1'b1);
      chk("unf_clr_vs_new", 32'(unf_dr), 32'h1);
      step(1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
      chk("unf_cleared", 32'(unf_wr), 32'h0);

      // Simultaneous push and pop
      step(1'b1, 1'b0, 10'h010, 1'b0, 1'b1);
      step(1'b1, 1'b0, 10'h020, 1'b0, 1'b1);
      step(1'b1, 1'b1, 10'h0AA, 1'b0, 1'b1);
      chk("pp_top", 32'(q_dr), 32'h0AA);
      chk("pp_count", 32'(count_dr), 32'h2);
      step(1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
      chk("pp_pop", 32'(q_dr), 32'h010);
      step(1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
      step(1'b1, 1'b1, 10'h0BB, 1'b0, 1'b1);
      chk("pp_empty_count", 32'(count_dr), 32'h1);
      chk("pp_empty_unf", 32'(unf_dr), 32'h0);

      // Reset mid-operation overrides a push
      step(1'b1, 1'b0, 10'h101, 1'b0, 1'b1);
      step(1'b1, 1'b0, 10'h102, 1'b0, 1'b1);
      step(1'b1, 1'b0, 10'h103, 1'b0, 1'b0);
      chk("rst_count", 32'(count_wr), 32'h0);
      chk("rst_q", 32'(q_wr), 32'h0);

      // Random mix, reset rarely
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
